// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package subtrator_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/subtrator_serial_completo.sv
// One-bit full subtractor cell: s = a - b - cin, cout = borrow out.
module subtrator_completo (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (~i_a & i_b) | (~(i_a ^ i_b) & i_cin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SUBTRATOR_SERIAL_OVF_EN.
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUBTRATOR_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CW-1:0]    r_count;
    logic             w_s;
    logic             w_cout;
    logic             w_last;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    logic             r_ovf;
`endif

    subtrator_completo u_cell (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_borrow),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    assign w_last = (r_count == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start)  w_next = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_SHIFT);
        done = (r_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_diff_sr <= '0;
            r_diff    <= '0;
            r_borrow  <= 1'b0;
            r_bout    <= 1'b0;
            r_count   <= '0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_a_sr   <= a;
                    r_b_sr   <= b;
                    r_borrow <= bin;
                    r_count  <= '0;
                end
                ST_SHIFT: begin
                    r_diff_sr <= {w_s, r_diff_sr[WIDTH-1:1]};
                    r_a_sr    <= r_a_sr >> 1;
                    r_b_sr    <= r_b_sr >> 1;
                    r_borrow  <= w_cout;
                    if (!w_last) r_count <= r_count + CW'(1);
                    // On the final bit the cell sees the operand MSBs, so results load here.
                    if (w_last) begin
                        r_diff <= {w_s, r_diff_sr[WIDTH-1:1]};
                        r_bout <= w_cout;
`ifdef SUBTRATOR_SERIAL_OVF_EN
                        r_ovf  <= (r_a_sr[0] ^ r_b_sr[0]) & (r_a_sr[0] ^ w_s);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (WIDTH=8): arithmetic/timing model plus directed literals.
// Covers the ovf output when SUBTRATOR_SERIAL_OVF_EN is defined.
module tb_subtrator_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    logic         ovf;
`endif

    subtrator_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUBTRATOR_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: accepting edge index and the arithmetic result of the operation in flight.
    int           e0 = 0;
    bit           pend = 1'b0;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;
    logic [W-1:0] held_diff;
    logic         held_bout;
    logic         held_ovf;
    logic         exp_busy;
    logic         exp_done;

    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        int u;
        int s;
        u = int'(av) - int'(bv) - int'(bv_in);
        s = int'($signed(av)) - int'($signed(bv)) - int'(bv_in);
        exp_diff = u[W-1:0];
        exp_bout = (u < 0);
        exp_ovf  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held_diff = '0;
            held_bout = 1'b0;
            held_ovf  = 1'b0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_diff", 32'(diff), 32'd0);
            check("rst_bout", 32'(bout), 32'd0);
        end else begin
            exp_busy = pend && (edge_cnt >= e0) && (edge_cnt < e0 + W);
            exp_done = pend && (edge_cnt == e0 + W);
            if (exp_done) begin
                held_diff = exp_diff;
                held_bout = exp_bout;
                held_ovf  = exp_ovf;
            end
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("diff", 32'(diff), 32'(held_diff));
            check("bout", 32'(bout), 32'(held_bout));
        end
`ifdef SUBTRATOR_SERIAL_OVF_EN
        check("ovf", 32'(ovf), 32'(rst ? 1'b0 : held_ovf));
`endif
    end

    task automatic scramble();
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
        @(negedge clk); #1;
        while (pend && (edge_cnt < e0 + W + 1)) begin
            scramble();
            @(negedge clk); #1;
        end
        a = av; b = bv; bin = bv_in; start = 1'b1;
        model(av, bv, bv_in);
        @(posedge clk); #1;
        e0    = edge_cnt;
        pend  = 1'b1;
        start = 1'b0;
        scramble();
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] d, input logic bo);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (done) break;
            scramble();
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_diff"}, 32'(diff), 32'(d));
        check({name, "_bout"}, 32'(bout), 32'(bo));
    endtask

    task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_diff", 32'(diff), 32'd0);

        start_op(8'd200, 8'd55, 1'b0);
        expect_result("200m55", 8'd145, 1'b0);
        start_op(8'd5, 8'd10, 1'b0);
        expect_result("5m10", 8'hFB, 1'b1);
        start_op(8'd0, 8'd0, 1'b1);
        expect_result("0m0b1", 8'hFF, 1'b1);

        // Start during SHIFT must be ignored.
        start_op(8'd9, 8'd4, 1'b0);
        repeat (2) @(posedge clk);
        #1 pulse_start(8'd1, 8'd2);
        expect_result("busy_start", 8'd5, 1'b0);

        // Start during the DONE cycle must be ignored too.
        start_op(8'd100, 8'd1, 1'b0);
        expect_result("done_start", 8'd99, 1'b0);
        pulse_start(8'd3, 8'd3);
        repeat (3) @(negedge clk);
        #1 check("idle_after_done_start", 32'(busy), 32'd0);

        // Reset in the 4th SHIFT cycle aborts the operation.
        start_op(8'd50, 8'd20, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; pend = 1'b0;
        #1 check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        start_op(8'd7, 8'd7, 1'b0);
        expect_result("7m7", 8'd0, 1'b0);

`ifdef SUBTRATOR_SERIAL_OVF_EN
        start_op(8'h80, 8'h01, 1'b0);
        expect_result("ovf1", 8'h7F, 1'b0);
        check("ovf1_ovf", 32'(ovf), 32'd1);
        start_op(8'h05, 8'h03, 1'b0);
        expect_result("ovf0", 8'h02, 1'b0);
        check("ovf0_ovf", 32'(ovf), 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_op(W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                pulse_start(W'($urandom), W'($urandom));
            end
        end
        repeat (W + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
